button_debounce: RTL and testbench

- Front-end stage for the operator push button that advances the speed/step display.
- Synchronises the raw mechanical button, debounces it, and emits a clean, glitch-free, registered press pulse.
- The downstream display/speed stage uses that pulse as its edge source.
- Also exports the debounced level and a long-hold flag for the motor control logic.

---
 rtl/ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 136 +++++++++++++
 tb/tb_button_debounce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared panel-control definitions: debounce FSM encoding and cycle constants
// for the 50 MHz build and for simulation-scale runs.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 500000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 10000000;
  localparam int unsigned DEF_CNT_W                = 25;

  localparam int unsigned SIM_DEBOUNCE_CYCLES      = 4;
  localparam int unsigned SIM_REPEAT_DELAY_CYCLES  = 20;
  localparam int unsigned SIM_REPEAT_PERIOD_CYCLES = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset to RST_VAL.
module sync_2ff #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: sync, debounce, registered press pulse, long-hold flag.
// Define BUTTON_AUTO_REPEAT_EN to emit repeat pulses while long_hold is high.
module button_debounce
  import ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int unsigned CNT_W                = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press,
  output logic btn_level,
  output logic long_hold
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_bad_param
    $error("button_debounce: DEBOUNCE_CYCLES and REPEAT_PERIOD_CYCLES must be >= 2");
  end

  // The IDLE->DEB_PRESS sample counts as the first stable press sample.
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(REPEAT_DELAY_CYCLES);

  logic             btn_s;
  logic             sync_btn;
  deb_state_t       state;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic             accept;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt;
`endif

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (btn_s)
  );

  always_comb begin
    sync_btn = ~btn_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      accept    <= 1'b0;
      press     <= 1'b0;
      btn_level <= 1'b0;
      long_hold <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      press  <= accept;
      accept <= 1'b0;
      case (state)
        IDLE: begin
          deb_cnt   <= '0;
          hold_cnt  <= '0;
          btn_level <= 1'b0;
          long_hold <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_cnt   <= '0;
`endif
          if (sync_btn) state <= DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!sync_btn) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == PRESS_LAST) begin
            state     <= HELD;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            btn_level <= 1'b1;
            accept    <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync_btn) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end else begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) long_hold <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            if (long_hold) begin
              if (rep_cnt == PER_LAST) begin
                rep_cnt <= '0;
                press   <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
`endif
          end
        end
        DEB_RELEASE: begin
          // hold_cnt and rep_cnt stay frozen so a bounce back to HELD resumes them.
          if (sync_btn) begin
            state   <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == REL_LAST) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            btn_level <= 1'b0;
            long_hold <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_cnt   <= '0;
`endif
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at simulation scale (4/20/8);
// expectations follow BUTTON_AUTO_REPEAT_EN when it is defined.
module tb_button_debounce;
  import ctrl_pkg::*;

  localparam int unsigned DEB = SIM_DEBOUNCE_CYCLES;
  localparam int unsigned DLY = SIM_REPEAT_DELAY_CYCLES;
  localparam int unsigned PER = SIM_REPEAT_PERIOD_CYCLES;

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic press;
  logic btn_level;
  logic long_hold;

  int n_checks = 0;
  int n_fail   = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES      (DEB),
    .REPEAT_DELAY_CYCLES  (DLY),
    .REPEAT_PERIOD_CYCLES (PER),
    .CNT_W                (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .press     (press),
    .btn_level (btn_level),
    .long_hold (long_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int n, output int pulses, output logic lvl_any, output logic lvl_all);
    pulses  = 0;
    lvl_any = 1'b0;
    lvl_all = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (press) pulses++;
      lvl_any = lvl_any | btn_level;
      lvl_all = lvl_all & btn_level;
    end
  endtask

  int   pulses;
  logic lany, lall;
  int   np, lv_at, lh_at;
  int   pc [8];

  initial begin
    assert (DEB >= 2) else $fatal(1, "DEBOUNCE_CYCLES below 2");
    assert (PER >= 2) else $fatal(1, "REPEAT_PERIOD_CYCLES below 2");

    rst   = 1'b0;
    btn_n = 1'b1;
    step(3);
    check("rst_press", int'(press), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_long", int'(long_hold), 0);
    rst = 1'b1;
    step(3);

    // clean press, held 30 cycles
    btn_n = 1'b0;
    step(5);
    check("clean_lvl5", int'(btn_level), 0);
    check("clean_press5", int'(press), 0);
    step(1);
    check("clean_lvl6", int'(btn_level), 1);
    check("clean_press6", int'(press), 0);
    step(1);
    check("clean_press7", int'(press), 1);
    step(1);
    check("clean_press8", int'(press), 0);
    step(22);
    check("clean_long30", int'(long_hold), 1);
    btn_n = 1'b1;
    step(6);
    check("clean_rel_lvl6", int'(btn_level), 1);
    step(1);
    check("clean_rel_lvl7", int'(btn_level), 0);
    check("clean_rel_long", int'(long_hold), 0);
    step(10);

    // bounce: 2 low / 2 high for 12 cycles, then released
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b0;
      run(2, np, lany, lall);
      pulses = np;
      check("bounce_lvl_lo", int'(lany), 0);
      btn_n = 1'b1;
      run(2, np, lany, lall);
      pulses += np;
      check("bounce_lvl_hi", int'(lany), 0);
      check("bounce_pulses", pulses, 0);
    end
    run(10, pulses, lany, lall);
    check("bounce_tail_pulses", pulses, 0);
    check("bounce_tail_lvl", int'(lany), 0);

    // release bounce while HELD
    btn_n = 1'b0;
    run(10, pulses, lany, lall);
    check("rb_first_pulse", pulses, 1);
    btn_n = 1'b1;
    run(2, np, lany, lall);
    pulses = np;
    check("rb_lvl_gap", int'(lall), 1);
    btn_n = 1'b0;
    run(12, np, lany, lall);
    pulses += np;
    check("rb_lvl_after", int'(lall), 1);
    check("rb_extra_pulses", pulses, 0);
    btn_n = 1'b1;
    step(12);
    check("rb_rel_lvl", int'(btn_level), 0);
    step(5);

    // long hold, 60 cycles low
    np = 0; lv_at = 0; lh_at = 0;
    foreach (pc[k]) pc[k] = 0;
    btn_n = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (press) begin
        if (np < 8) pc[np] = i;
        np++;
      end
      if (long_hold && lh_at == 0) lh_at = i;
      if (btn_level && lv_at == 0) lv_at = i;
    end
    check("lh_level_rise", lv_at, 6);
    check("lh_long_rise", lh_at, 26);
    check("lh_first_pulse", pc[0], 7);
`ifdef BUTTON_AUTO_REPEAT_EN
    check("lh_pulse_count", np, 5);
    check("lh_repeat1", pc[1], 34);
    check("lh_repeat2", pc[2], 42);
`else
    check("lh_pulse_count", np, 1);
`endif
    btn_n = 1'b1;
    run(12, pulses, lany, lall);
    check("lh_release_pulses", pulses, 0);
    check("lh_release_long", int'(long_hold), 0);
    check("lh_release_lvl", int'(btn_level), 0);
    step(5);

    // reset while HELD, button kept down
    btn_n = 1'b0;
    step(10);
    check("rm_held_lvl", int'(btn_level), 1);
    rst = 1'b0;
    #1;
    check("rm_async_out", int'({press, btn_level, long_hold}), 0);
    step(2);
    rst = 1'b1;
    step(6);
    check("rm_press6", int'(press), 0);
    check("rm_lvl6", int'(btn_level), 1);
    step(1);
    check("rm_press7", int'(press), 1);
    btn_n = 1'b1;
    step(12);
    check("rm_rel_lvl", int'(btn_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
